// File: rtl/jtag_reg_bank_pkg.sv
// Shared opcodes, capture constants and instruction decode for the JTAG register bank.
// Decode honours IDCODE_REG_EN: when undefined, opcode 'h1 falls back to BYPASS.
package jtag_reg_bank_pkg;

    localparam int unsigned JTAG_IR_W_DEF = 4;
    localparam int unsigned JTAG_DR_W_DEF = 32;
    localparam int unsigned JTAG_ID_W     = 32;

    localparam logic [31:0] JTAG_IDCODE_V_DEF = 32'h1000_0FF1;
    localparam logic [31:0] JTAG_BYPASS       = 32'hFFFF_FFFF;
    localparam logic [31:0] JTAG_IDCODE       = 32'h0000_0001;
    localparam logic [31:0] JTAG_USER_DATA    = 32'h0000_0008;
    localparam logic [31:0] JTAG_USER_STATUS  = 32'h0000_0009;
    localparam logic [1:0]  JTAG_IR_CAPT      = 2'b01;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER_DATA,
        DR_USER_STATUS
    } dr_sel_e;

    // Unrecognised opcodes select the 1-bit bypass path.
    function automatic dr_sel_e decode_ir(input logic [31:0] ir);
        dr_sel_e sel;
        case (ir)
`ifdef IDCODE_REG_EN
            JTAG_IDCODE:      sel = DR_IDCODE;
`endif
            JTAG_USER_DATA:   sel = DR_USER_DATA;
            JTAG_USER_STATUS: sel = DR_USER_STATUS;
            default:          sel = DR_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtag_reg_bank_if.sv
// TAP-side control/data bundle for the JTAG register bank.
// master = TAP controller / test driver, slave = register bank.
interface jtag_reg_bank_if #(
    parameter int unsigned IR_W = 4,
    parameter int unsigned DR_W = 32
);
    logic            rst;
    logic            enable;
    logic            select;
    logic            captdr;
    logic            shiftdr;
    logic            updatedr;
    logic            captir;
    logic            shiftir;
    logic            updateir;
    logic            tdi;
    logic [DR_W-1:0] status_in;
    logic            tdo;
    logic            tdo_en;
    logic [IR_W-1:0] ir_q;
    logic [DR_W-1:0] dr_q;
    logic            dr_upd;

    modport master (
        output rst, enable, select, captdr, shiftdr, updatedr,
               captir, shiftir, updateir, tdi, status_in,
        input  tdo, tdo_en, ir_q, dr_q, dr_upd
    );

    modport slave (
        input  rst, enable, select, captdr, shiftdr, updatedr,
               captir, shiftir, updateir, tdi, status_in,
        output tdo, tdo_en, ir_q, dr_q, dr_upd
    );
endinterface

// File: rtl/jtag_shift_reg.sv
// Capture/shift register with a selectable serial insertion point (i_tap).
// Bits above the tap hold during shifting, so a short register can live in a wide one.
module jtag_shift_reg #(
    parameter int unsigned W = 32
) (
    input  logic                 tck,
    input  logic                 trst,
    input  logic                 i_clr,
    input  logic                 i_cap,
    input  logic                 i_shift,
    input  logic [W-1:0]         i_cap_val,
    input  logic [$clog2(W)-1:0] i_tap,
    input  logic                 i_tdi,
    output logic [W-1:0]         o_q,
    output logic                 o_lsb
);
    localparam int unsigned TAP_W = $clog2(W);

    logic [W-1:0] r_sh;
    logic [W-1:0] w_sr;
    logic [W-1:0] w_shifted;

    assign w_sr = r_sh >> 1;

    always_comb begin
        w_shifted = r_sh;
        for (int unsigned j = 0; j < W; j++) begin
            if (TAP_W'(j) == i_tap) begin
                w_shifted[j] = i_tdi;
            end else if (TAP_W'(j) < i_tap) begin
                w_shifted[j] = w_sr[j];
            end
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_sh <= '0;
        end else if (i_clr) begin
            r_sh <= '0;
        end else if (i_cap) begin
            r_sh <= i_cap_val;
        end else if (i_shift) begin
            r_sh <= w_shifted;
        end
    end

    assign o_q   = r_sh;
    assign o_lsb = r_sh[0];
endmodule

// File: rtl/jtag_reg_bank.sv
// JTAG instruction register plus BYPASS/IDCODE/USER_DATA/USER_STATUS data registers.
// IDCODE_REG_EN: when defined, IDCODE storage exists and is the reset instruction.
module jtag_reg_bank
    import jtag_reg_bank_pkg::*;
#(
    parameter int unsigned IR_W     = JTAG_IR_W_DEF,
    parameter int unsigned DR_W     = JTAG_DR_W_DEF,
    parameter logic [31:0] IDCODE_V = JTAG_IDCODE_V_DEF
) (
    input logic             tck,
    input logic             trst,
    jtag_reg_bank_if.slave  jtag
);
    localparam int unsigned IR_TAP_W = $clog2(IR_W);
    localparam int unsigned DR_TAP_W = $clog2(DR_W);
`ifdef IDCODE_REG_EN
    localparam logic [IR_W-1:0] IR_RST = IR_W'(JTAG_IDCODE);
`else
    localparam logic [IR_W-1:0] IR_RST = IR_W'(JTAG_BYPASS);
`endif
    localparam logic [IR_W-1:0] IR_CAPT = IR_W'(JTAG_IR_CAPT);

    logic                w_clr;
    logic                w_ir_any;
    logic                w_ir_load;
    logic                w_dr_cap;
    logic                w_dr_shift;
    logic                w_dr_load;
    logic                w_tdo_en;
    logic                w_ir_lsb;
    logic                w_dr_lsb;
    logic [IR_W-1:0]     w_ir_sh;
    logic [DR_W-1:0]     w_dr_sh;
    logic [DR_W-1:0]     w_dr_cap_val;
    logic [DR_TAP_W-1:0] w_dr_tap;
    dr_sel_e             w_sel;

    logic [IR_W-1:0]     r_ir_q;
    logic [DR_W-1:0]     r_dr_q;
    logic                r_byp;
    logic                r_load_d;
    logic                r_dr_upd;

    assign w_clr     = !jtag.rst;
    assign w_ir_any  = jtag.captir | jtag.shiftir | jtag.updateir;
    assign w_ir_load = jtag.updateir & !jtag.captir & !jtag.shiftir;
    assign w_sel     = decode_ir(32'(r_ir_q));

    // IR strobes mask all DR activity; within the DR path capture beats shift beats update.
    assign w_dr_cap   = !w_ir_any & jtag.captdr & (w_sel != DR_BYPASS);
    assign w_dr_shift = !w_ir_any & !jtag.captdr & jtag.shiftdr & (w_sel != DR_BYPASS);
    assign w_dr_load  = !w_ir_any & !jtag.captdr & !jtag.shiftdr & jtag.updatedr
                      & (w_sel == DR_USER_DATA);

    always_comb begin
        w_dr_cap_val = '0;
        w_dr_tap     = DR_TAP_W'(DR_W - 1);
        case (w_sel)
            DR_IDCODE: begin
                w_dr_cap_val = DR_W'(IDCODE_V);
                w_dr_tap     = DR_TAP_W'(JTAG_ID_W - 1);
            end
            DR_USER_DATA:   w_dr_cap_val = r_dr_q;
            DR_USER_STATUS: w_dr_cap_val = jtag.status_in;
            default:        w_dr_cap_val = '0;
        endcase
    end

    jtag_shift_reg #(.W(IR_W)) u_ir_sh (
        .tck       (tck),
        .trst      (trst),
        .i_clr     (w_clr),
        .i_cap     (jtag.captir),
        .i_shift   (jtag.shiftir),
        .i_cap_val (IR_CAPT),
        .i_tap     (IR_TAP_W'(IR_W - 1)),
        .i_tdi     (jtag.tdi),
        .o_q       (w_ir_sh),
        .o_lsb     (w_ir_lsb)
    );

    jtag_shift_reg #(.W(DR_W)) u_dr_sh (
        .tck       (tck),
        .trst      (trst),
        .i_clr     (w_clr),
        .i_cap     (w_dr_cap),
        .i_shift   (w_dr_shift),
        .i_cap_val (w_dr_cap_val),
        .i_tap     (w_dr_tap),
        .i_tdi     (jtag.tdi),
        .o_q       (w_dr_sh),
        .o_lsb     (w_dr_lsb)
    );

    // dr_upd fires only on the first of a run of consecutive USER_DATA updates.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_ir_q   <= IR_RST;
            r_dr_q   <= '0;
            r_byp    <= 1'b0;
            r_load_d <= 1'b0;
            r_dr_upd <= 1'b0;
        end else if (w_clr) begin
            r_ir_q   <= IR_RST;
            r_dr_q   <= '0;
            r_byp    <= 1'b0;
            r_load_d <= 1'b0;
            r_dr_upd <= 1'b0;
        end else begin
            if (w_ir_load) begin
                r_ir_q <= w_ir_sh;
            end
            if (!w_ir_any && (w_sel == DR_BYPASS)) begin
                if (jtag.captdr) begin
                    r_byp <= 1'b0;
                end else if (jtag.shiftdr) begin
                    r_byp <= jtag.tdi;
                end
            end
            if (w_dr_load) begin
                r_dr_q <= w_dr_sh;
            end
            r_load_d <= w_dr_load;
            r_dr_upd <= w_dr_load & !r_load_d;
        end
    end

    assign w_tdo_en    = jtag.enable & (jtag.shiftdr | jtag.shiftir);
    assign jtag.tdo_en = w_tdo_en;
    assign jtag.tdo    = w_tdo_en & (jtag.select ? w_ir_lsb
                                   : ((w_sel == DR_BYPASS) ? r_byp : w_dr_lsb));
    assign jtag.ir_q   = r_ir_q;
    assign jtag.dr_q   = r_dr_q;
    assign jtag.dr_upd = r_dr_upd;
endmodule
